// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state, field widths and address decode helpers for the L1 data cache
package dcache_pkg;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    localparam int TAG_W    = 23;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:OFFSET_W+INDEX_W];
    endfunction
    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction
    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: EX/MEM request port and off-chip line port of the data cache
interface dcache_if;
    import dcache_pkg::*;
    logic              cpu_read_i;
    logic              cpu_write_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_wdata_i;
    logic [31:0]       cpu_rdata_o;
    logic              stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    modport slave (
        input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
    modport master (
        output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays with combinational read and masked synchronous write
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = LINE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_W-1:0]     index,
    output logic [TAG_W-1:0]       rd_tag,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [LINE_BITS-1:0]   rd_line,
    input  logic                   we,
    input  logic [LINE_BITS/32-1:0] wmask,
    input  logic [LINE_BITS-1:0]   wline,
    input  logic [TAG_W-1:0]       wtag,
    input  logic                   wdirty
);
    logic [TAG_W-1:0]     tags [NUM_SETS];
    logic [LINE_BITS-1:0] data [NUM_SETS];
    logic [NUM_SETS-1:0]  valid;
    logic [NUM_SETS-1:0]  dirty;
    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_line  = data[index];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[index] <= 1'b1;
            dirty[index] <= wdirty;
            tags[index]  <= wtag;
        end
    end
    // data words carry no reset; valid alone decides whether they mean anything
    always_ff @(posedge clk) begin
        for (int w = 0; w < LINE_BITS / 32; w++)
            if (rst_n && we && wmask[w]) data[index][w*32 +: 32] <= wline[w*32 +: 32];
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 data cache controller for the MEM stage
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = LINE_W,
    parameter int ADDR_W    = 32
) (
    input logic     clk_i,
    input logic     rst_i,
    dcache_if.slave bus
);
    localparam int WORDS = LINE_BITS / 32;
    state_t               state;
    logic [TAG_W-1:0]     tag;
    logic [TAG_W-1:0]     rd_tag;
    logic [INDEX_W-1:0]   index;
    logic [2:0]           word;
    logic                 rd_valid, rd_dirty, hit, req, load, fill, we, victim_dirty, unused;
    logic [LINE_BITS-1:0] rd_line;
    logic [31:0]          rd_word, rdata_q;
    logic [WORDS-1:0]     wmask;
    logic [ADDR_W-1:0]    victim_addr, fill_addr;
    assign tag          = addr_tag(bus.cpu_addr_i);
    assign index        = addr_index(bus.cpu_addr_i);
    assign word         = addr_word(bus.cpu_addr_i);
    assign unused       = ^bus.cpu_addr_i[1:0];
    assign req          = bus.cpu_read_i | bus.cpu_write_i;
    assign load         = bus.cpu_read_i & ~bus.cpu_write_i;
    assign hit          = rd_valid && rd_tag == tag;
    assign victim_dirty = rd_valid && rd_dirty;
    assign rd_word      = rd_line[{word, 5'd0} +: 32];
    assign victim_addr  = {rd_tag, index, 5'd0};
    assign fill_addr    = {tag, index, 5'd0};
    assign fill         = state == ALLOCATE && bus.mem_ack_i;
    assign we           = fill || (state == IDLE && bus.cpu_write_i && hit);
    assign wmask        = fill ? '1 : WORDS'(1) << word;
    assign bus.stall_o     = state != IDLE || (req && !hit);
    assign bus.cpu_rdata_o = state == IDLE && load && hit ? rd_word : rdata_q;
    dcache_sram #(.NUM_SETS(NUM_SETS), .LINE_BITS(LINE_BITS)) u_sram (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .index   (index),
        .rd_tag  (rd_tag),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .rd_line (rd_line),
        .we      (we),
        .wmask   (wmask),
        .wline   (fill ? bus.mem_rdata_i : {WORDS{bus.cpu_wdata_i}}),
        .wtag    (tag),
        .wdirty  (!fill)
    );
    // the frozen EX/MEM register keeps cpu_addr_i stable, so the fill address is taken live
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state            <= IDLE;
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_wdata_o  <= '0;
            rdata_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load && hit) rdata_q <= rd_word;
                    if (req && !hit) begin
                        state            <= victim_dirty ? WRITEBACK : ALLOCATE;
                        bus.mem_enable_o <= 1'b1;
                        bus.mem_write_o  <= victim_dirty;
                        bus.mem_addr_o   <= victim_dirty ? victim_addr : fill_addr;
                        bus.mem_wdata_o  <= rd_line;
                    end
                end
                WRITEBACK: if (bus.mem_ack_i) begin
                    state           <= ALLOCATE;
                    bus.mem_write_o <= 1'b0;
                    bus.mem_addr_o  <= fill_addr;
                end
                ALLOCATE: if (bus.mem_ack_i) begin
                    state            <= IDLE;
                    bus.mem_enable_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
